// File: rtl/dotprod_pkg.sv
// Shared types and helpers for the pipelined dot-product engine.
// Holds the FSM encoding, legal read-latency range and overflow rule.
package dotprod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    // Only the MSBs of both addends and the sum are needed to recover
    // either the unsigned carry out or the signed overflow condition.
    function automatic logic add_ovf(
        input logic sgn,
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb
    );
        if (sgn)
            return (a_msb == b_msb) && (sum_msb != a_msb);
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
    endfunction

endpackage

// File: rtl/dotprod_mac.sv
// Multiply-accumulate stage: registered product followed by a wrapping
// accumulator with a sticky overflow flag.
module dotprod_mac
    import dotprod_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf,
    output logic              busy
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_nxt;
    logic             prod_vld;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;

    // Operands are widened to full product width before multiplying so the
    // upper half of the product is not lost to context sizing.
    generate
        if (SIGNED != 0) begin : g_signed
            assign prod_nxt = $signed({{DATA_W{a[DATA_W-1]}}, a}) *
                              $signed({{DATA_W{b[DATA_W-1]}}, b});
            assign prod_ext = ACC_W'($signed(prod));
        end else begin : g_unsigned
            assign prod_nxt = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
            assign prod_ext = ACC_W'(prod);
        end
    endgenerate

    assign sum  = acc + prod_ext;
    assign busy = prod_vld;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            prod_vld <= valid;
            if (valid)
                prod <= prod_nxt;
            if (prod_vld) begin
                acc <= sum;
                if (add_ovf(SIGNED != 0, acc[ACC_W-1], prod_ext[ACC_W-1], sum[ACC_W-1]))
                    ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dotprod_pipe.sv
// Pipelined dot-product engine with ap_start/ap_idle/ap_done handshake;
// issues one address pair per clock and absorbs MEM_LAT cycles of read latency.
module dotprod_pipe
    import dotprod_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int ACC_W   = 64,
    parameter int MEM_LAT = 1,
    parameter int SIGNED  = 0
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic [ADDR_W-1:0] n,
    output logic [ADDR_W-1:0] a_address0,
    output logic              a_ce0,
    input  logic [DATA_W-1:0] a_q0,
    output logic [ADDR_W-1:0] b_address0,
    output logic              b_ce0,
    input  logic [DATA_W-1:0] b_q0,
    output logic [ACC_W-1:0]  ap_return,
    output logic              ap_ovf
);

    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $error("dotprod_pipe: ACC_W must be at least 2*DATA_W");
        end
        if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
            $error("dotprod_pipe: MEM_LAT out of range 1..4");
        end
    endgenerate

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              issue;
    logic              last_issue;
    logic              drain_done;
    logic [MEM_LAT:0]  vld_pipe;
    logic [MEM_LAT:1]  vld_sr;
    logic              mac_busy;

    assign accept     = (state == IDLE) && ap_start;
    assign issue      = (state == ISSUE);
    assign last_issue = (cnt == n_q - ADDR_W'(1));
    assign vld_pipe   = {vld_sr, issue};

    // With no read in flight, a pending product is being folded into the
    // accumulator on this edge, so the result is final in the next cycle.
    assign drain_done = ~|vld_sr && mac_busy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (ap_start) state_nxt = (n == '0) ? DONE : ISSUE;
            ISSUE: if (last_issue) state_nxt = DRAIN;
            DRAIN: if (drain_done) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= IDLE;
            n_q    <= '0;
            cnt    <= '0;
            vld_sr <= '0;
        end else begin
            state  <= state_nxt;
            vld_sr <= vld_pipe[MEM_LAT-1:0];
            if (accept) begin
                n_q <= n;
                cnt <= '0;
            end else if (issue && !last_issue) begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    dotprod_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .valid (vld_pipe[MEM_LAT]),
        .clr   (accept),
        .a     (a_q0),
        .b     (b_q0),
        .acc   (ap_return),
        .ovf   (ap_ovf),
        .busy  (mac_busy)
    );

    assign ap_idle    = (state == IDLE);
    assign ap_done    = (state == DONE);
    assign a_ce0      = issue;
    assign b_ce0      = issue;
    assign a_address0 = cnt;
    assign b_address0 = cnt;

endmodule
